// File: rtl/branch_resolve.sv
// Branch/jump resolution in EX: tracks ID/EX prediction slots, raises flush with a
// redirect PC on misprediction, and emits predictor updates and perf counters.
module branch_resolve #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic             if_pred_taken,
  input  logic [31:0]      if_pred_pc,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic             ex_cond_true,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_rs1,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic             upd_valid,
  output logic             upd_correct,
  output logic [31:0]      upd_pc,
  output logic [31:0]      upd_target,
  output logic [CNT_W-1:0] cf_count,
  output logic [CNT_W-1:0] mispred_count
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
  } slot_t;

  slot_t id_q, ex_q;

  logic        is_cf, actual_taken, mispredict;
  logic [31:0] br_target, jalr_sum, target, seq_pc, actual_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      id_q <= '0;
      ex_q <= '0;
    end else if (flush) begin
      id_q.valid <= 1'b0;
      ex_q.valid <= 1'b0;
    end else if (stall) begin
      ex_q.valid <= 1'b0;
    end else begin
      id_q <= '{valid: if_valid, pc: if_pc, pred_taken: if_pred_taken, pred_pc: if_pred_pc};
      ex_q <= id_q;
    end
  end

  always_comb begin
    is_cf        = ex_is_branch | ex_is_jal | ex_is_jalr;
    br_target    = ex_q.pc + ex_imm;
    jalr_sum     = ex_rs1 + ex_imm;
    target       = ex_is_jalr ? {jalr_sum[31:1], 1'b0} : br_target;
    seq_pc       = ex_q.pc + 32'd4;
    actual_taken = ex_is_jal | ex_is_jalr | (ex_is_branch & ex_cond_true);
    actual_next  = actual_taken ? target : seq_pc;
    // Non-control-flow instructions fall out of the same compare: actual_next is pc+4.
    mispredict   = ex_q.valid & (actual_next != ex_q.pred_pc);

    flush        = mispredict;
    redirect_pc  = mispredict ? actual_next : 32'd0;
    upd_valid    = ex_q.valid & is_cf;
    upd_correct  = ex_q.valid & (ex_q.pred_taken == actual_taken) &
                   (!actual_taken | (ex_q.pred_pc == target));
    upd_pc       = ex_q.valid ? ex_q.pc : 32'd0;
    upd_target   = ex_q.valid ? target : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cf_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (upd_valid && (cf_count != '1))
        cf_count <= cf_count + 1'b1;
      if (upd_valid && flush && (mispred_count != '1))
        mispred_count <= mispred_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed checks of branch_resolve with narrow counters so saturation is reachable.
module tb_branch_resolve;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, stall, if_valid, if_pred_taken;
  logic [31:0]   if_pc, if_pred_pc;
  logic          ex_is_branch, ex_is_jal, ex_is_jalr, ex_cond_true;
  logic [31:0]   ex_imm, ex_rs1;
  logic          flush, upd_valid, upd_correct;
  logic [31:0]   redirect_pc, upd_pc, upd_target;
  logic [CW-1:0] cf_count, mispred_count;

  int errors = 0;
  int checks = 0;
  int exp_cf = 0;
  int exp_mis = 0;

  branch_resolve #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_pc(if_pred_pc),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_cond_true(ex_cond_true), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .flush(flush), .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_correct(upd_correct),
    .upd_pc(upd_pc), .upd_target(upd_target), .cf_count(cf_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic br, input logic jal, input logic jalr, input logic cond,
                        input logic [31:0] imm, input logic [31:0] rs1);
    ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_cond_true = cond; ex_imm = imm; ex_rs1 = rs1;
  endtask

  // Places one instruction in IF, then walks it into the EX slot (two edges).
  task automatic issue(input logic [31:0] pc, input logic pt, input logic [31:0] ppc);
    if_valid = 1'b1; if_pc = pc; if_pred_taken = pt; if_pred_pc = ppc;
    step();
    if_valid = 1'b0;
    step();
  endtask

  function automatic int sat(input int v);
    return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
  endfunction

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; if_valid = 1'b0; if_pc = '0; if_pred_taken = 1'b0; if_pred_pc = '0;
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(); step();
    reset = 1'b0;
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", flush); end
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_upd_valid: got %b expected 0", upd_valid); end
    checks++; if (redirect_pc !== 32'd0) begin errors++; $display("FAIL reset_redirect: got %h expected 0", redirect_pc); end
    checks++; if (cf_count !== 4'd0 || mispred_count !== 4'd0) begin errors++;
      $display("FAIL reset_counters: got cf=%0d mis=%0d expected 0/0", cf_count, mispred_count); end
    step();
    checks++; if ({upd_pc, upd_target, upd_correct} !== 65'd0) begin errors++;
      $display("FAIL post_reset_outputs: got pc=%h tgt=%h ok=%b expected zeros", upd_pc, upd_target, upd_correct); end
  endtask

  task automatic test_branch_mispredict();
    issue(32'h100, 1'b0, 32'h104);
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'd0);
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mp_flush: got %b expected 1", flush); end
    checks++; if (redirect_pc !== 32'h140) begin errors++; $display("FAIL mp_redirect: got %h expected 00000140", redirect_pc); end
    checks++; if (upd_valid !== 1'b1 || upd_correct !== 1'b0) begin errors++;
      $display("FAIL mp_upd: got valid=%b correct=%b expected 1/0", upd_valid, upd_correct); end
    checks++; if (upd_pc !== 32'h100 || upd_target !== 32'h140) begin errors++;
      $display("FAIL mp_upd_pc_tgt: got %h/%h expected 00000100/00000140", upd_pc, upd_target); end
    step();
    exp_cf = sat(exp_cf); exp_mis = sat(exp_mis);
    checks++; if (mispred_count !== 4'(exp_mis) || cf_count !== 4'(exp_cf)) begin errors++;
      $display("FAIL mp_counters: got cf=%0d mis=%0d expected %0d/%0d", cf_count, mispred_count, exp_cf, exp_mis); end
  endtask

  task automatic test_branch_correct();
    // Taken backward branch, predicted correctly.
    issue(32'h200, 1'b1, 32'h180);
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FF80, 32'd0);
    #1;
    checks++; if (flush !== 1'b0 || upd_correct !== 1'b1) begin errors++;
      $display("FAIL taken_ok: got flush=%b correct=%b expected 0/1", flush, upd_correct); end
    checks++; if (upd_target !== 32'h180) begin errors++; $display("FAIL taken_tgt: got %h expected 00000180", upd_target); end
    step();
    exp_cf = sat(exp_cf);
    checks++; if (cf_count !== 4'(exp_cf) || mispred_count !== 4'(exp_mis)) begin errors++;
      $display("FAIL taken_counters: got cf=%0d mis=%0d expected %0d/%0d", cf_count, mispred_count, exp_cf, exp_mis); end
    // Not-taken branch: target still reported.
    issue(32'h500, 1'b0, 32'h504);
    set_ex(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'd0);
    #1;
    checks++; if (flush !== 1'b0 || upd_correct !== 1'b1 || upd_target !== 32'h540) begin errors++;
      $display("FAIL nt_ok: got flush=%b correct=%b tgt=%h expected 0/1/00000540", flush, upd_correct, upd_target); end
    step();
    exp_cf = sat(exp_cf);
  endtask

  task automatic test_jalr();
    issue(32'h300, 1'b1, 32'h1004);
    set_ex(1'b0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h1001);
    #1;
    checks++; if (upd_target !== 32'h1004) begin errors++; $display("FAIL jalr_tgt: got %h expected 00001004", upd_target); end
    checks++; if (flush !== 1'b0 || upd_correct !== 1'b1 || upd_valid !== 1'b1) begin errors++;
      $display("FAIL jalr_ok: got flush=%b correct=%b valid=%b expected 0/1/1", flush, upd_correct, upd_valid); end
    step();
    exp_cf = sat(exp_cf);
  endtask

  task automatic test_non_cf();
    issue(32'h400, 1'b0, 32'h500);
    set_ex(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'd0);
    #1;
    checks++; if (flush !== 1'b1 || redirect_pc !== 32'h404) begin errors++;
      $display("FAIL noncf_flush: got flush=%b redirect=%h expected 1/00000404", flush, redirect_pc); end
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL noncf_upd: got %b expected 0", upd_valid); end
    step();
    checks++; if (cf_count !== 4'(exp_cf) || mispred_count !== 4'(exp_mis)) begin errors++;
      $display("FAIL noncf_counters: got cf=%0d mis=%0d expected %0d/%0d", cf_count, mispred_count, exp_cf, exp_mis); end
  endtask

  task automatic test_stall();
    if_valid = 1'b1; if_pc = 32'h600; if_pred_taken = 1'b0; if_pred_pc = 32'h604;
    set_ex(1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'd0);
    step();
    if_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (upd_valid !== 1'b0 || flush !== 1'b0) begin errors++;
        $display("FAIL stall_hold%0d: got valid=%b flush=%b expected 0/0", i, upd_valid, flush); end
    end
    stall = 1'b0;
    step();
    checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h600 || upd_correct !== 1'b1) begin errors++;
      $display("FAIL stall_release: got valid=%b pc=%h correct=%b expected 1/00000600/1", upd_valid, upd_pc, upd_correct); end
    step();
    exp_cf = sat(exp_cf);
    checks++; if (cf_count !== 4'(exp_cf)) begin errors++; $display("FAIL stall_cf: got %0d expected %0d", cf_count, exp_cf); end
  endtask

  task automatic test_flush_stall();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    if_valid = 1'b1; if_pc = 32'h700; if_pred_taken = 1'b0; if_pred_pc = 32'h704;
    step();
    if_pc = 32'h704; if_pred_pc = 32'h708;
    step();
    if_valid = 1'b0;
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'd0);
    stall = 1'b1;
    #1;
    checks++; if (flush !== 1'b1 || redirect_pc !== 32'h710) begin errors++;
      $display("FAIL fs_flush: got flush=%b redirect=%h expected 1/00000710", flush, redirect_pc); end
    step();
    exp_cf = sat(exp_cf); exp_mis = sat(exp_mis);
    stall = 1'b0;
    #1;
    checks++; if (flush !== 1'b0 || upd_valid !== 1'b0) begin errors++;
      $display("FAIL fs_ex_killed: got flush=%b valid=%b expected 0/0", flush, upd_valid); end
    step();
    checks++; if (upd_valid !== 1'b0 || flush !== 1'b0) begin errors++;
      $display("FAIL fs_id_killed: got valid=%b flush=%b expected 0/0", upd_valid, flush); end
    checks++; if (cf_count !== 4'(exp_cf) || mispred_count !== 4'(exp_mis)) begin errors++;
      $display("FAIL fs_counters: got cf=%0d mis=%0d expected %0d/%0d", cf_count, mispred_count, exp_cf, exp_mis); end
  endtask

  task automatic test_saturate_and_reset();
    for (int i = 0; i < 14; i++) begin
      issue(32'h100, 1'b0, 32'h104);
      set_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'd0);
      step();
      exp_cf = sat(exp_cf); exp_mis = sat(exp_mis);
    end
    checks++; if (mispred_count !== 4'hF || cf_count !== 4'hF || exp_mis != 15) begin errors++;
      $display("FAIL saturate: got cf=%0d mis=%0d expected 15/15", cf_count, mispred_count); end
    // Mispredict sitting in EX when reset hits.
    issue(32'h100, 1'b0, 32'h104);
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rst_pre_flush: got %b expected 1", flush); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    exp_cf = 0; exp_mis = 0;
    checks++; if (cf_count !== 4'd0 || mispred_count !== 4'd0) begin errors++;
      $display("FAIL rst_counters: got cf=%0d mis=%0d expected 0/0", cf_count, mispred_count); end
    checks++; if (flush !== 1'b0 || upd_valid !== 1'b0 || redirect_pc !== 32'd0) begin errors++;
      $display("FAIL rst_flush: got flush=%b valid=%b redirect=%h expected 0/0/0", flush, upd_valid, redirect_pc); end
  endtask

  task automatic test_back_to_back();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    if_valid = 1'b1; if_pc = 32'h800; if_pred_taken = 1'b0; if_pred_pc = 32'h804;
    step();
    if_pc = 32'h804; if_pred_pc = 32'h808;
    step();
    if_valid = 1'b0;
    #1;
    checks++; if (upd_pc !== 32'h800 || flush !== 1'b0 || upd_valid !== 1'b0) begin errors++;
      $display("FAIL b2b_first: got pc=%h flush=%b valid=%b expected 00000800/0/0", upd_pc, flush, upd_valid); end
    step();
    checks++; if (upd_pc !== 32'h804 || flush !== 1'b0) begin errors++;
      $display("FAIL b2b_second: got pc=%h flush=%b expected 00000804/0", upd_pc, flush); end
    step();
    checks++; if (upd_pc !== 32'd0 || cf_count !== 4'd0) begin errors++;
      $display("FAIL b2b_drain: got pc=%h cf=%0d expected 0/0", upd_pc, cf_count); end
  endtask

  initial begin
    test_reset();
    test_branch_mispredict();
    test_branch_correct();
    test_jalr();
    test_non_cf();
    test_stall();
    test_flush_stall();
    test_saturate_and_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter CNT_W, default 16: width of the performance counters.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 stall  in  1  load-use hold: the ID slot holds and a bubble enters the EX slot.
REQ-005 if_valid  in  1  IF stage holds a real instruction.
REQ-006 if_pc  in  32  PC fetched this cycle.
REQ-007 if_pred_taken  in  1  predictor taken/not-taken decision for if_pc.
REQ-008 if_pred_pc  in  32  predictor next-PC for if_pc.
REQ-009 ex_is_branch, ex_is_jal, ex_is_jalr  in  1 each  decoded class of the EX instruction; one-hot or all zero.
REQ-010 ex_cond_true  in  1  branch comparison result from the ALU.
REQ-011 ex_imm  in  32  sign-extended immediate of the EX instruction.
REQ-012 ex_rs1  in  32  forwarded rs1 value of the EX instruction.
REQ-013 flush  out  1  kill the IF/ID and ID/EX instructions.
REQ-014 redirect_pc  out  32  fetch PC to use when flush=1.
REQ-015 upd_valid  out  1  predictor update strobe (control-flow instruction resolved).
REQ-016 upd_correct  out  1  prediction was fully correct.
REQ-017 upd_pc  out  32  PC of the resolved instruction.
REQ-018 upd_target  out  32  computed taken target.
REQ-019 cf_count, mispred_count  out  CNT_W each  resolved control-flow and misprediction counters.

Function
REQ-020 The block shall keep two tracking slots, ID and EX; each holds {valid, pc, pred_taken, pred_pc}.
REQ-021 Each cycle, with no stall and no flush, the block shall load the ID slot from the IF inputs (valid=if_valid) and the EX slot from the ID slot.
REQ-022 When stall=1 and flush=0, the ID slot shall hold and the EX slot shall load valid=0.
REQ-023 When flush=1, both slots shall load valid=0 at the next edge, regardless of stall (flush wins).
REQ-024 Target arithmetic shall be modulo 2^32: branch/JAL target = ex_pc + ex_imm; JALR target = (ex_rs1 + ex_imm) & 32'hFFFF_FFFE.
REQ-025 actual_taken = ex_is_jal | ex_is_jalr | (ex_is_branch & ex_cond_true); actual_next = actual_taken ? target : ex_pc + 4.
REQ-026 flush shall be asserted combinationally in the same cycle when the EX slot is valid and actual_next != ex_pred_pc; redirect_pc = actual_next.
REQ-027 A valid non-control-flow EX instruction with pred_pc != pc+4 shall assert flush with redirect_pc = pc+4 and upd_valid=0.
REQ-028 upd_valid shall equal EX valid & (ex_is_branch | ex_is_jal | ex_is_jalr).
REQ-029 The update outputs shall be driven as follows: upd_pc = ex_pc; upd_target = target (computed even when not taken).
REQ-030 upd_correct shall equal (pred_taken == actual_taken) & (!actual_taken | pred_pc == target).
REQ-031 While flush=0, redirect_pc shall be don't-care, driven as 0.
REQ-032 At the edge, cf_count shall increment when upd_valid=1, and mispred_count shall increment when upd_valid & flush; both saturate at all-ones.
REQ-033 Invalid EX slot shall force flush=0 and upd_valid=0, with ex_* inputs ignored.

Reset
REQ-034 While reset=1, at each edge both slots shall become valid=0 and both counters 0; reset overrides stall and flush.
REQ-035 In the cycle after reset deasserts, all outputs shall be 0 until a valid instruction reaches EX (earliest: 2 edges after if_valid=1).
REQ-036 Reset asserted mid-flush shall discard the pending redirect; no counter increment on that edge.

Verification
REQ-037 Branch at 0x100, pred not-taken, ex_cond_true=1, imm=0x40 -> flush=1, redirect_pc=0x140, upd_valid=1, upd_correct=0, mispred_count 0->1.
REQ-038 Branch at 0x200, pred taken to 0x180, imm=-0x80, cond true -> flush=0, upd_correct=1, cf_count+1, mispred_count unchanged.
REQ-039 JALR at 0x300, rs1=0x1001, imm=0x4, pred_pc=0x1004 -> target 0x1004, flush=0, upd_correct=1.
REQ-040 Stall=1 for 2 cycles with a branch in ID -> EX slot valid=0 for 2 cycles, no upd_valid, branch resolves in the cycle after stall drops.
REQ-041 Mispredict in EX with stall=1 the same cycle -> next cycle both slots invalid, flush=0, upd_valid=0.
REQ-042 mispred_count forced to all-ones, another mispredict -> count stays all-ones; reset=1 one edge -> both counters 0, flush=0.
